// File: rtl/axil_master_param_if.sv
`default_nettype none
// ============================================================================
// Module   : axil_master_param_if
// Purpose  : AXI4-Lite bus bundle (AW/W/B/AR/R) with master and slave views.
// Revision : 1.0
// ============================================================================
interface axil_master_param_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                    AWVALID;
    logic                    AWREADY;
    logic [ADDR_WIDTH-1:0]   AWADDR;
    logic [2:0]              AWPROT;
    logic                    WVALID;
    logic                    WREADY;
    logic [DATA_WIDTH-1:0]   WDATA;
    logic [DATA_WIDTH/8-1:0] WSTRB;
    logic                    BVALID;
    logic                    BREADY;
    logic [1:0]              BRESP;
    logic                    ARVALID;
    logic                    ARREADY;
    logic [ADDR_WIDTH-1:0]   ARADDR;
    logic [2:0]              ARPROT;
    logic                    RVALID;
    logic                    RREADY;
    logic [DATA_WIDTH-1:0]   RDATA;
    logic [1:0]              RRESP;

    modport master (
        output AWVALID, AWADDR, AWPROT, WVALID, WDATA, WSTRB, BREADY,
               ARVALID, ARADDR, ARPROT, RREADY,
        input  AWREADY, WREADY, BVALID, BRESP, ARREADY, RVALID, RDATA, RRESP
    );

    modport slave (
        input  AWVALID, AWADDR, AWPROT, WVALID, WDATA, WSTRB, BREADY,
               ARVALID, ARADDR, ARPROT, RREADY,
        output AWREADY, WREADY, BVALID, BRESP, ARREADY, RVALID, RDATA, RRESP
    );
endinterface
`default_nettype wire

// File: rtl/axil_master_param.sv
`default_nettype none
// ============================================================================
// Module   : axil_master_param
// Purpose  : Parametrised AXI4-Lite master with independent read/write FSMs,
//            registered response reporting and sticky response watchdogs.
// Revision : 1.0
// ============================================================================
module axil_master_param #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int TO_CNT_WIDTH   = 16
) (
    input  wire                      ACLK,
    input  wire                      ARESET,
    axil_master_param_if.master      m_axi,

    input  wire                      wr_cmd_valid,
    output logic                     wr_cmd_ready,
    input  wire [ADDR_WIDTH-1:0]     wr_cmd_addr,
    input  wire [DATA_WIDTH-1:0]     wr_cmd_data,
    input  wire [DATA_WIDTH/8-1:0]   wr_cmd_strb,
    input  wire [2:0]                wr_cmd_prot,
    output logic                     wr_done,
    output logic [1:0]               wr_resp,

    input  wire                      rd_cmd_valid,
    output logic                     rd_cmd_ready,
    input  wire [ADDR_WIDTH-1:0]     rd_cmd_addr,
    input  wire [2:0]                rd_cmd_prot,
    output logic                     rd_done,
    output logic [DATA_WIDTH-1:0]    rd_data,
    output logic [1:0]               rd_resp,

    output logic                     wr_timeout,
    output logic                     rd_timeout,
    input  wire                      timeout_clr
);

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_REQ  = 2'd1,
        W_RESP = 2'd2
    } wr_state_t;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_ADDR = 2'd1,
        R_DATA = 2'd2
    } rd_state_t;

    // ------------------------------------------------------------------
    // Write channel
    // ------------------------------------------------------------------
    wr_state_t               r_wr_state;
    logic                    r_awvalid;
    logic                    r_wvalid;
    logic                    r_bready;
    logic                    r_aw_done;
    logic                    r_w_done;
    logic [ADDR_WIDTH-1:0]   r_awaddr;
    logic [2:0]              r_awprot;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic [DATA_WIDTH/8-1:0] r_wstrb;
    logic                    r_wr_done;
    logic [1:0]              r_wr_resp;

    logic w_aw_hs;
    logic w_w_hs;
    logic w_b_hs;

    assign w_aw_hs = r_awvalid & m_axi.AWREADY;
    assign w_w_hs  = r_wvalid  & m_axi.WREADY;
    assign w_b_hs  = r_bready  & m_axi.BVALID;

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_wr_state <= W_IDLE;
            r_awvalid  <= 1'b0;
            r_wvalid   <= 1'b0;
            r_bready   <= 1'b0;
            r_aw_done  <= 1'b0;
            r_w_done   <= 1'b0;
            r_awaddr   <= '0;
            r_awprot   <= 3'b000;
            r_wdata    <= '0;
            r_wstrb    <= '0;
            r_wr_done  <= 1'b0;
            r_wr_resp  <= 2'b00;
        end else begin
            r_wr_done <= 1'b0;
            case (r_wr_state)
                W_IDLE: begin
                    if (wr_cmd_valid) begin
                        r_awaddr   <= wr_cmd_addr;
                        r_awprot   <= wr_cmd_prot;
                        r_wdata    <= wr_cmd_data;
                        r_wstrb    <= wr_cmd_strb;
                        r_awvalid  <= 1'b1;
                        r_wvalid   <= 1'b1;
                        r_aw_done  <= 1'b0;
                        r_w_done   <= 1'b0;
                        r_wr_state <= W_REQ;
                    end
                end
                W_REQ: begin
                    // AW and W retire independently; B is opened once both have.
                    if (w_aw_hs) begin
                        r_awvalid <= 1'b0;
                        r_aw_done <= 1'b1;
                    end
                    if (w_w_hs) begin
                        r_wvalid <= 1'b0;
                        r_w_done <= 1'b1;
                    end
                    if ((r_aw_done | w_aw_hs) & (r_w_done | w_w_hs)) begin
                        r_bready   <= 1'b1;
                        r_wr_state <= W_RESP;
                    end
                end
                W_RESP: begin
                    if (w_b_hs) begin
                        r_bready   <= 1'b0;
                        r_wr_resp  <= m_axi.BRESP;
                        r_wr_done  <= 1'b1;
                        r_wr_state <= W_IDLE;
                    end
                end
                default: begin
                    r_wr_state <= W_IDLE;
                end
            endcase
        end
    end

    assign m_axi.AWVALID = r_awvalid;
    assign m_axi.AWADDR  = r_awaddr;
    assign m_axi.AWPROT  = r_awprot;
    assign m_axi.WVALID  = r_wvalid;
    assign m_axi.WDATA   = r_wdata;
    assign m_axi.WSTRB   = r_wstrb;
    assign m_axi.BREADY  = r_bready;

    assign wr_cmd_ready  = (r_wr_state == W_IDLE);
    assign wr_done       = r_wr_done;
    assign wr_resp       = r_wr_resp;

    // ------------------------------------------------------------------
    // Read channel
    // ------------------------------------------------------------------
    rd_state_t               r_rd_state;
    logic                    r_arvalid;
    logic                    r_rready;
    logic [ADDR_WIDTH-1:0]   r_araddr;
    logic [2:0]              r_arprot;
    logic                    r_rd_done;
    logic [DATA_WIDTH-1:0]   r_rd_data;
    logic [1:0]              r_rd_resp;

    logic w_ar_hs;
    logic w_r_hs;

    assign w_ar_hs = r_arvalid & m_axi.ARREADY;
    assign w_r_hs  = r_rready  & m_axi.RVALID;

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_rd_state <= R_IDLE;
            r_arvalid  <= 1'b0;
            r_rready   <= 1'b0;
            r_araddr   <= '0;
            r_arprot   <= 3'b000;
            r_rd_done  <= 1'b0;
            r_rd_data  <= '0;
            r_rd_resp  <= 2'b00;
        end else begin
            r_rd_done <= 1'b0;
            case (r_rd_state)
                R_IDLE: begin
                    if (rd_cmd_valid) begin
                        r_araddr   <= rd_cmd_addr;
                        r_arprot   <= rd_cmd_prot;
                        r_arvalid  <= 1'b1;
                        r_rd_state <= R_ADDR;
                    end
                end
                R_ADDR: begin
                    if (w_ar_hs) begin
                        r_arvalid  <= 1'b0;
                        r_rready   <= 1'b1;
                        r_rd_state <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (w_r_hs) begin
                        r_rready   <= 1'b0;
                        r_rd_data  <= m_axi.RDATA;
                        r_rd_resp  <= m_axi.RRESP;
                        r_rd_done  <= 1'b1;
                        r_rd_state <= R_IDLE;
                    end
                end
                default: begin
                    r_rd_state <= R_IDLE;
                end
            endcase
        end
    end

    assign m_axi.ARVALID = r_arvalid;
    assign m_axi.ARADDR  = r_araddr;
    assign m_axi.ARPROT  = r_arprot;
    assign m_axi.RREADY  = r_rready;

    assign rd_cmd_ready  = (r_rd_state == R_IDLE);
    assign rd_done       = r_rd_done;
    assign rd_data       = r_rd_data;
    assign rd_resp       = r_rd_resp;

    // ------------------------------------------------------------------
    // Response watchdogs: index 0 = write, index 1 = read
    // ------------------------------------------------------------------
    logic [1:0] w_busy;
    logic [1:0] w_start;
    logic [1:0] w_to_flag;

    assign w_busy  = {(r_rd_state != R_IDLE), (r_wr_state != W_IDLE)};
    assign w_start = {(r_rd_state == R_IDLE) & rd_cmd_valid,
                      (r_wr_state == W_IDLE) & wr_cmd_valid};

    generate
        if (TIMEOUT_CYCLES > 0) begin : g_wdog
            localparam logic [TO_CNT_WIDTH-1:0] c_TO_LIMIT = TO_CNT_WIDTH'(TIMEOUT_CYCLES);
            localparam logic [TO_CNT_WIDTH-1:0] c_TO_LAST  = TO_CNT_WIDTH'(TIMEOUT_CYCLES - 1);

            for (genvar i = 0; i < 2; i++) begin : g_ch
                logic [TO_CNT_WIDTH-1:0] r_cnt;
                logic                    r_to;
                logic                    w_set;

                // Fires only on the step that reaches the limit, so a clear
                // during a long stall is not immediately undone.
                assign w_set = w_busy[i] & (r_cnt == c_TO_LAST);

                always_ff @(posedge ACLK) begin
                    if (ARESET) begin
                        r_cnt <= '0;
                        r_to  <= 1'b0;
                    end else begin
                        if (w_start[i]) begin
                            r_cnt <= '0;
                        end else if (w_busy[i] && (r_cnt != c_TO_LIMIT)) begin
                            r_cnt <= r_cnt + 1'b1;
                        end

                        if (w_set) begin
                            r_to <= 1'b1;
                        end else if (timeout_clr) begin
                            r_to <= 1'b0;
                        end
                    end
                end

                assign w_to_flag[i] = r_to;
            end
        end else begin : g_no_wdog
            assign w_to_flag = 2'b00;
        end
    endgenerate

    assign wr_timeout = w_to_flag[0];
    assign rd_timeout = w_to_flag[1];

endmodule
`default_nettype wire

// File: tb/tb_axil_master_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_axil_master_param
// Purpose  : Directed self-checking bench for axil_master_param.
// Revision : 1.0
// ============================================================================
module tb_axil_master_param;
    localparam int AW = 32;
    localparam int DW = 32;

    logic ACLK   = 1'b0;
    logic ARESET = 1'b1;
    always #5 ACLK = ~ACLK;

    axil_master_param_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) axi ();

    logic          wr_cmd_valid;
    logic          wr_cmd_ready;
    logic [AW-1:0] wr_cmd_addr;
    logic [DW-1:0] wr_cmd_data;
    logic [3:0]    wr_cmd_strb;
    logic [2:0]    wr_cmd_prot;
    logic          wr_done;
    logic [1:0]    wr_resp;
    logic          rd_cmd_valid;
    logic          rd_cmd_ready;
    logic [AW-1:0] rd_cmd_addr;
    logic [2:0]    rd_cmd_prot;
    logic          rd_done;
    logic [DW-1:0] rd_data;
    logic [1:0]    rd_resp;
    logic          wr_timeout;
    logic          rd_timeout;
    logic          timeout_clr;

    axil_master_param #(
        .ADDR_WIDTH    (AW),
        .DATA_WIDTH    (DW),
        .TIMEOUT_CYCLES(8),
        .TO_CNT_WIDTH  (8)
    ) dut (
        .ACLK        (ACLK),
        .ARESET      (ARESET),
        .m_axi       (axi.master),
        .wr_cmd_valid(wr_cmd_valid),
        .wr_cmd_ready(wr_cmd_ready),
        .wr_cmd_addr (wr_cmd_addr),
        .wr_cmd_data (wr_cmd_data),
        .wr_cmd_strb (wr_cmd_strb),
        .wr_cmd_prot (wr_cmd_prot),
        .wr_done     (wr_done),
        .wr_resp     (wr_resp),
        .rd_cmd_valid(rd_cmd_valid),
        .rd_cmd_ready(rd_cmd_ready),
        .rd_cmd_addr (rd_cmd_addr),
        .rd_cmd_prot (rd_cmd_prot),
        .rd_done     (rd_done),
        .rd_data     (rd_data),
        .rd_resp     (rd_resp),
        .wr_timeout  (wr_timeout),
        .rd_timeout  (rd_timeout),
        .timeout_clr (timeout_clr)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        wr_cmd_valid = 1'b0; wr_cmd_addr = '0; wr_cmd_data = '0; wr_cmd_strb = '0; wr_cmd_prot = '0;
        rd_cmd_valid = 1'b0; rd_cmd_addr = '0; rd_cmd_prot = '0; timeout_clr = 1'b0;
        axi.AWREADY = 1'b0; axi.WREADY = 1'b0; axi.BVALID = 1'b0; axi.BRESP = 2'b00;
        axi.ARREADY = 1'b0; axi.RVALID = 1'b0; axi.RDATA = '0; axi.RRESP = 2'b00;

        // Reset state
        tick(); tick();
        chk("rst_awvalid", axi.AWVALID, 0);
        chk("rst_wvalid",  axi.WVALID, 0);
        chk("rst_bready",  axi.BREADY, 0);
        chk("rst_arvalid", axi.ARVALID, 0);
        chk("rst_rready",  axi.RREADY, 0);
        chk("rst_done",    {wr_done, rd_done}, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_to",      {wr_timeout, rd_timeout}, 0);
        ARESET = 1'b0;
        tick();
        chk("idle_ready", {wr_cmd_ready, rd_cmd_ready}, 2'b11);

        // 1: simple write, slave always ready
        wr_cmd_valid = 1'b1; wr_cmd_addr = 32'h0000_0010; wr_cmd_data = 32'hDEAD_BEEF;
        wr_cmd_strb = 4'hF; wr_cmd_prot = 3'b010;
        axi.AWREADY = 1'b1; axi.WREADY = 1'b1;
        tick();
        wr_cmd_valid = 1'b0;
        chk("t1_valids", {axi.AWVALID, axi.WVALID, axi.BREADY}, 3'b110);
        chk("t1_awaddr", axi.AWADDR, 32'h10);
        chk("t1_wdata",  axi.WDATA, 32'hDEAD_BEEF);
        chk("t1_wstrb",  axi.WSTRB, 4'hF);
        chk("t1_awprot", axi.AWPROT, 3'b010);
        chk("t1_busy",   wr_cmd_ready, 0);
        tick();
        chk("t1_bready", {axi.AWVALID, axi.WVALID, axi.BREADY}, 3'b001);
        axi.AWREADY = 1'b0; axi.WREADY = 1'b0;
        axi.BVALID = 1'b1; axi.BRESP = 2'b00;
        tick();
        axi.BVALID = 1'b0;
        chk("t1_done",   {wr_done, axi.BREADY, wr_cmd_ready}, 3'b101);
        chk("t1_resp",   wr_resp, 2'b00);
        tick();
        chk("t1_pulse",  wr_done, 0);

        // 2: W accepted three cycles before AW
        wr_cmd_valid = 1'b1; wr_cmd_addr = 32'h0000_0044; wr_cmd_data = 32'hCAFE_F00D;
        wr_cmd_strb = 4'h3; wr_cmd_prot = 3'b000;
        axi.WREADY = 1'b1;
        tick();
        wr_cmd_valid = 1'b0;
        chk("t2_valids", {axi.AWVALID, axi.WVALID}, 2'b11);
        tick();
        axi.WREADY = 1'b0;
        chk("t2_w_first", {axi.AWVALID, axi.WVALID, axi.BREADY}, 3'b100);
        wr_cmd_valid = 1'b1; wr_cmd_addr = 32'h0000_0999;
        tick(); tick();
        wr_cmd_valid = 1'b0;
        chk("t2_aw_wait", {axi.AWVALID, axi.WVALID, axi.BREADY}, 3'b100);
        chk("t2_addr_held", axi.AWADDR, 32'h44);
        chk("t2_strb_held", axi.WSTRB, 4'h3);
        axi.AWREADY = 1'b1;
        tick();
        axi.AWREADY = 1'b0;
        chk("t2_bready", {axi.AWVALID, axi.BREADY}, 2'b01);
        axi.BVALID = 1'b1; axi.BRESP = 2'b11;
        tick();
        axi.BVALID = 1'b0;
        chk("t2_done", {wr_done, wr_resp}, 3'b111);
        tick();
        chk("t2_single", {wr_done, wr_resp, axi.AWVALID}, 4'b0110);

        // 3: read with 5-cycle data latency, SLVERR passes through
        rd_cmd_valid = 1'b1; rd_cmd_addr = 32'h0000_0020; rd_cmd_prot = 3'b001;
        axi.ARREADY = 1'b1;
        tick();
        rd_cmd_valid = 1'b0;
        chk("t3_arvalid", {axi.ARVALID, axi.RREADY, rd_cmd_ready}, 3'b100);
        chk("t3_araddr",  axi.ARADDR, 32'h20);
        chk("t3_arprot",  axi.ARPROT, 3'b001);
        tick();
        axi.ARREADY = 1'b0;
        chk("t3_rready",  {axi.ARVALID, axi.RREADY}, 2'b01);
        tick(); tick(); tick(); tick();
        chk("t3_wait",    {rd_done, axi.RREADY}, 2'b01);
        axi.RVALID = 1'b1; axi.RDATA = 32'h1234_5678; axi.RRESP = 2'b10;
        tick();
        axi.RVALID = 1'b0; axi.RDATA = 32'h0;
        chk("t3_done",    {rd_done, axi.RREADY, rd_resp}, 4'b1010);
        chk("t3_data",    rd_data, 32'h1234_5678);
        tick();
        chk("t3_single",  {rd_done, rd_cmd_ready}, 2'b01);
        chk("t3_held",    rd_data, 32'h1234_5678);

        // 4: concurrent write and read issued together
        wr_cmd_valid = 1'b1; wr_cmd_addr = 32'h0000_0100; wr_cmd_data = 32'hA5A5_5A5A; wr_cmd_strb = 4'hF;
        rd_cmd_valid = 1'b1; rd_cmd_addr = 32'h0000_0200;
        axi.AWREADY = 1'b1; axi.WREADY = 1'b1; axi.ARREADY = 1'b1;
        tick();
        wr_cmd_valid = 1'b0; rd_cmd_valid = 1'b0;
        chk("t4_req", {axi.AWVALID, axi.WVALID, axi.ARVALID}, 3'b111);
        chk("t4_addrs", {axi.AWADDR, axi.ARADDR}, {32'h100, 32'h200});
        tick();
        axi.AWREADY = 1'b0; axi.WREADY = 1'b0; axi.ARREADY = 1'b0;
        chk("t4_ready", {axi.BREADY, axi.RREADY, axi.AWVALID, axi.ARVALID}, 4'b1100);
        axi.BVALID = 1'b1; axi.BRESP = 2'b01;
        tick();
        axi.BVALID = 1'b0;
        chk("t4_wdone", {wr_done, wr_resp, rd_done, axi.RREADY}, 5'b10101);
        axi.RVALID = 1'b1; axi.RDATA = 32'h0BAD_F00D; axi.RRESP = 2'b00;
        tick();
        axi.RVALID = 1'b0;
        chk("t4_rdone", {rd_done, rd_resp, wr_done}, 4'b1000);
        chk("t4_rdata", rd_data, 32'h0BAD_F00D);

        // 5: write watchdog, B withheld
        wr_cmd_valid = 1'b1; wr_cmd_addr = 32'h0000_0300; wr_cmd_data = 32'h1;
        axi.AWREADY = 1'b1; axi.WREADY = 1'b1;
        tick();
        wr_cmd_valid = 1'b0;
        tick();
        axi.AWREADY = 1'b0; axi.WREADY = 1'b0;
        repeat (6) tick();
        chk("t5_before", wr_timeout, 0);
        tick();
        chk("t5_set", wr_timeout, 1);
        repeat (12) tick();
        chk("t5_stuck", {wr_timeout, rd_timeout, axi.BREADY}, 3'b101);
        axi.BVALID = 1'b1; axi.BRESP = 2'b10;
        tick();
        axi.BVALID = 1'b0;
        chk("t5_done", {wr_done, wr_resp, wr_timeout}, 4'b1101);
        timeout_clr = 1'b1;
        tick();
        timeout_clr = 1'b0;
        chk("t5_clr", wr_timeout, 0);

        // 5b: clear in the same cycle as the set event
        wr_cmd_valid = 1'b1; wr_cmd_addr = 32'h0000_0304;
        axi.AWREADY = 1'b1; axi.WREADY = 1'b1;
        tick();
        wr_cmd_valid = 1'b0;
        tick();
        axi.AWREADY = 1'b0; axi.WREADY = 1'b0;
        repeat (6) tick();
        chk("t5b_restart", wr_timeout, 0);
        timeout_clr = 1'b1;
        tick();
        timeout_clr = 1'b0;
        chk("t5b_set_wins", wr_timeout, 1);
        axi.BVALID = 1'b1; axi.BRESP = 2'b00;
        tick();
        axi.BVALID = 1'b0;
        chk("t5b_done", {wr_done, wr_resp}, 3'b100);
        tick();

        // 6: reset while AWVALID is pending
        wr_cmd_valid = 1'b1; wr_cmd_addr = 32'h0000_0055; wr_cmd_data = 32'h77;
        tick();
        wr_cmd_valid = 1'b0;
        chk("t6_pending", {axi.AWVALID, axi.WVALID}, 2'b11);
        ARESET = 1'b1;
        tick();
        chk("t6_valids", {axi.AWVALID, axi.WVALID, axi.BREADY, axi.ARVALID, axi.RREADY}, 5'b0);
        chk("t6_payload", {axi.AWADDR, axi.WDATA, axi.WSTRB, axi.AWPROT}, 0);
        chk("t6_status", {wr_done, wr_resp, wr_timeout, wr_cmd_ready}, 5'b00001);
        chk("t6_rd_data", rd_data, 0);
        ARESET = 1'b0;
        tick();
        chk("t6_no_done", {wr_done, axi.AWVALID, wr_cmd_ready}, 3'b001);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
